// File: rtl/procyon_rom_loader.sv
// Sequential ROM-to-write-port copier: walks ROM words and streams them out over valid/ready.
// Optional running XOR of written data when PROCYON_ROM_LOADER_CHECKSUM_EN is defined.
module procyon_rom_loader #(
    parameter int OPTN_DATA_WIDTH      = 8,
    parameter int OPTN_ROM_DEPTH       = 8,
    parameter int OPTN_BASE_ADDR       = 0,
    parameter int OPTN_DEST_ADDR_WIDTH = 32,
    parameter int OPTN_DEST_BASE       = 0,
    parameter int ROM_IDX_WIDTH        = $clog2(OPTN_ROM_DEPTH),
    parameter int CNT_WIDTH            = ROM_IDX_WIDTH + 1
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_start,
    input  logic [CNT_WIDTH-1:0]            i_count,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [ROM_IDX_WIDTH-1:0]        o_rom_rd_addr,
    input  logic [OPTN_DATA_WIDTH-1:0]      i_rom_data_in,
    output logic                            o_wr_valid,
    input  logic                            i_wr_ready,
    output logic [OPTN_DEST_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [OPTN_DATA_WIDTH-1:0]      o_wr_data
`ifdef PROCYON_ROM_LOADER_CHECKSUM_EN
    ,
    output logic [OPTN_DATA_WIDTH-1:0]      o_checksum
`endif
);

    // state   | meaning
    // IDLE    | waiting for i_start
    // SEND    | o_wr_data/o_wr_addr presented, waiting for handshakes
    // DONE    | one-cycle completion pulse
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0]            DEPTH_C     = CNT_WIDTH'(OPTN_ROM_DEPTH);
    localparam logic [CNT_WIDTH-1:0]            ONE_C       = CNT_WIDTH'(1);
    localparam logic [ROM_IDX_WIDTH-1:0]        BASE_C      = ROM_IDX_WIDTH'(OPTN_BASE_ADDR);
    localparam logic [OPTN_DEST_ADDR_WIDTH-1:0] DEST_BASE_C = OPTN_DEST_ADDR_WIDTH'(OPTN_DEST_BASE);

    logic [1:0]               state;
    logic [ROM_IDX_WIDTH-1:0] idx;
    logic [ROM_IDX_WIDTH-1:0] rd_idx;
    logic [CNT_WIDTH-1:0]     remaining;
    logic [CNT_WIDTH-1:0]     ecount;
    logic                     handshake;

    assign ecount     = (i_count > DEPTH_C) ? DEPTH_C : i_count;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);
    assign o_wr_valid = (state == ST_SEND);
    assign handshake  = o_wr_valid && i_wr_ready;

    // While sending, look one word ahead so the next word is captured on the handshake edge.
    assign rd_idx        = (state == ST_SEND) ? (idx + ROM_IDX_WIDTH'(1)) : idx;
    assign o_rom_rd_addr = BASE_C + rd_idx;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            remaining <= '0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (i_start) begin
                        if (ecount != '0) begin
                            o_wr_data <= i_rom_data_in;
                            o_wr_addr <= DEST_BASE_C;
                            remaining <= ecount;
                            state     <= ST_SEND;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (remaining > ONE_C) begin
                            idx       <= idx + ROM_IDX_WIDTH'(1);
                            o_wr_data <= i_rom_data_in;
                            o_wr_addr <= o_wr_addr + OPTN_DEST_ADDR_WIDTH'(1);
                            remaining <= remaining - ONE_C;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PROCYON_ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            o_checksum <= '0;
        end else if (state == ST_IDLE && i_start) begin
            o_checksum <= '0;
        end else if (handshake) begin
            o_checksum <= o_checksum ^ o_wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_procyon_rom_loader.sv
// Directed bench for procyon_rom_loader: ROM holds 0x10..0x17, destination base 0x100.
// Checksum scenario is compiled in only when PROCYON_ROM_LOADER_CHECKSUM_EN is defined.
module tb_procyon_rom_loader;

    logic        clk;
    logic        n_rst;
    logic        i_start;
    logic [3:0]  i_count;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_rom_rd_addr;
    logic [7:0]  i_rom_data_in;
    logic        o_wr_valid;
    logic        i_wr_ready;
    logic [31:0] o_wr_addr;
    logic [7:0]  o_wr_data;
`ifdef PROCYON_ROM_LOADER_CHECKSUM_EN
    logic [7:0]  o_checksum;
`endif

    logic [7:0] rom [8];
    int checks;
    int errors;

    procyon_rom_loader #(
        .OPTN_DATA_WIDTH(8),
        .OPTN_ROM_DEPTH(8),
        .OPTN_BASE_ADDR(0),
        .OPTN_DEST_ADDR_WIDTH(32),
        .OPTN_DEST_BASE('h100)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_start(i_start),
        .i_count(i_count),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_rom_rd_addr(o_rom_rd_addr),
        .i_rom_data_in(i_rom_data_in),
        .o_wr_valid(o_wr_valid),
        .i_wr_ready(i_wr_ready),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data)
`ifdef PROCYON_ROM_LOADER_CHECKSUM_EN
        ,
        .o_checksum(o_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_rom_data_in = rom[o_rom_rd_addr];

    task automatic test_reset();
        n_rst = 1'b0; i_start = 1'b0; i_count = '0; i_wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_wr_valid} !== 3'b000 || o_wr_addr !== 32'h0 ||
            o_wr_data !== 8'h0 || o_rom_rd_addr !== 3'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b valid=%b addr=%h data=%h rd=%0d, need all 0",
                     o_busy, o_done, o_wr_valid, o_wr_addr, o_wr_data, o_rom_rd_addr);
        end
        n_rst = 1'b1;
    endtask

    // Full transfer with ready held high; count 8 (exact) or 12 (clamped to 8).
    task automatic test_stream(input logic [3:0] cnt, input string name);
        int hs;
        hs = 0;
        @(negedge clk);
        i_start = 1'b1; i_count = cnt; i_wr_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            checks++;
            if (o_wr_valid !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0 ||
                o_wr_data !== 8'h10 + 8'(c) || o_wr_addr !== 32'h100 + c) begin
                errors++;
                $display("FAIL %s word %0d: valid=%b busy=%b done=%b data=%h addr=%h, need 1 1 0 %h %h",
                         name, c, o_wr_valid, o_busy, o_done, o_wr_data, o_wr_addr, 8'h10 + 8'(c), 32'h100 + c);
            end else hs++;
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_wr_valid !== 1'b0 || o_busy !== 1'b1 || hs != 8) begin
            errors++;
            $display("FAIL %s done cycle: done=%b valid=%b busy=%b good_words=%0d, need 1 0 1 8",
                     name, o_done, o_wr_valid, o_busy, hs);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b valid=%b, need 0 0 0", name, o_done, o_busy, o_wr_valid);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        hs = 0;
        @(negedge clk);
        i_start = 1'b1; i_count = 4'd8; i_wr_ready = 1'b0;
        for (int c = 0; c < 40 && hs < 8; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_wr_ready = c[0];
            checks++;
            if (o_wr_valid !== 1'b1 || o_wr_data !== 8'h10 + 8'(hs) || o_wr_addr !== 32'h100 + hs) begin
                errors++;
                $display("FAIL backpressure cyc %0d: valid=%b data=%h addr=%h, need 1 %h %h",
                         c, o_wr_valid, o_wr_data, o_wr_addr, 8'h10 + 8'(hs), 32'h100 + hs);
            end
            if (o_wr_valid && i_wr_ready) hs++;
        end
        @(negedge clk);
        i_wr_ready = 1'b1;
        checks++;
        if (hs != 8 || o_done !== 1'b1 || o_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure end: handshakes=%0d done=%b valid=%b, need 8 1 0", hs, o_done, o_wr_valid);
        end
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        i_start = 1'b1; i_count = 4'd0;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_wr_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_count t+1: done=%b valid=%b busy=%b, need 1 0 1", o_done, o_wr_valid, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_wr_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_count t+2: done=%b valid=%b busy=%b, need 0 0 0", o_done, o_wr_valid, o_busy);
        end
    endtask

    task automatic test_midreset();
        @(negedge clk);
        i_start = 1'b1; i_count = 4'd8; i_wr_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        @(negedge clk);
        n_rst = 1'b0;
        checks++;
        if (o_wr_data !== 8'h13) begin
            errors++;
            $display("FAIL midreset pre: data=%h, need 13 after 3 handshakes", o_wr_data);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_wr_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL midreset post %0d: valid=%b busy=%b done=%b, need 0 0 0", c, o_wr_valid, o_busy, o_done);
            end
            @(negedge clk);
        end
        i_start = 1'b1; i_count = 4'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            checks++;
            if (o_wr_valid !== 1'b1 || o_wr_data !== 8'h10 + 8'(c) || o_wr_addr !== 32'h100 + c) begin
                errors++;
                $display("FAIL midreset restart %0d: valid=%b data=%h addr=%h, need 1 %h %h",
                         c, o_wr_valid, o_wr_data, o_wr_addr, 8'h10 + 8'(c), 32'h100 + c);
            end
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset restart done: done=%b valid=%b, need 1 0", o_done, o_wr_valid);
        end
    endtask

    // count=3 under backpressure while i_start stays high; the stream must be unaffected.
    task automatic test_start_while_busy();
        int hs;
        hs = 0;
        @(negedge clk);
        i_start = 1'b1; i_count = 4'd3; i_wr_ready = 1'b0;
        @(negedge clk);
        i_count = 4'd8;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            if (c > 0) @(negedge clk);
            i_wr_ready = c[0];
            checks++;
            if (o_wr_valid !== 1'b1 || o_wr_data !== 8'h10 + 8'(hs) || o_wr_addr !== 32'h100 + hs) begin
                errors++;
                $display("FAIL busy_start cyc %0d: valid=%b data=%h addr=%h, need 1 %h %h",
                         c, o_wr_valid, o_wr_data, o_wr_addr, 8'h10 + 8'(hs), 32'h100 + hs);
            end
            if (o_wr_valid && i_wr_ready) hs++;
        end
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (hs != 3 || o_done !== 1'b1 || o_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_start done: handshakes=%0d done=%b valid=%b, need 3 1 0", hs, o_done, o_wr_valid);
        end
`ifdef PROCYON_ROM_LOADER_CHECKSUM_EN
        checks++;
        if (o_checksum !== 8'h13) begin
            errors++;
            $display("FAIL checksum at done: got %h, need 13", o_checksum);
        end
`endif
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_start idle: busy=%b valid=%b, need 0 0", o_busy, o_wr_valid);
        end
`ifdef PROCYON_ROM_LOADER_CHECKSUM_EN
        checks++;
        if (o_checksum !== 8'h13) begin
            errors++;
            $display("FAIL checksum held: got %h, need 13", o_checksum);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) rom[i] = 8'h10 + 8'(i);
        test_reset();
        test_stream(4'd8, "stream8");
        test_backpressure();
        test_zero_count();
        test_stream(4'd12, "clamp12");
        test_midreset();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/procyon_rom_loader.md
Name: procyon_rom_loader

Overview:
- Initiator/reader for the asynchronous-read ROM port.
- Walks ROM addresses sequentially, captures each word and streams it out as write requests over a valid/ready interface, e.g. to copy boot code into RAM.
- Software/control logic starts a transfer with a word count and receives a one-cycle done pulse when it completes.
- Sits between the boot ROM and the memory/bus write port.

Parameters:
- OPTN_DATA_WIDTH, 8, ROM word and write-data width.
- OPTN_ROM_DEPTH, 8, number of ROM words.
- OPTN_BASE_ADDR, 0, first ROM address; must be representable in ROM_IDX_WIDTH.
- OPTN_DEST_ADDR_WIDTH, 32, width of destination write address.
- OPTN_DEST_BASE, 0, destination address of word 0.
- ROM_IDX_WIDTH, $clog2(OPTN_ROM_DEPTH), derived; do not override.
- CNT_WIDTH, ROM_IDX_WIDTH+1, derived; do not override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- n_rst  in  1  synchronous active-low reset.
- i_start  in  1  start transfer; sampled only in IDLE.
- i_count  in  CNT_WIDTH  number of words to copy; sampled with i_start.
- o_busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive.
- o_done  out  1  one-cycle completion pulse.
- o_rom_rd_addr  out  ROM_IDX_WIDTH  ROM read address (ROM answers combinationally).
- i_rom_data_in  in  OPTN_DATA_WIDTH  ROM read data.
- o_wr_valid  out  1  write request valid.
- i_wr_ready  in  1  write request accepted when valid && ready.
- o_wr_addr  out  OPTN_DEST_ADDR_WIDTH  write address.
- o_wr_data  out  OPTN_DATA_WIDTH  write data.

Behaviour:
- Reset (n_rst low at a clock edge):
  - state IDLE; o_busy=0, o_done=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0.
  - Index idx=0, so o_rom_rd_addr=OPTN_BASE_ADDR.
  - Takes effect on the clock edge; an in-flight transfer is abandoned with no further writes and no done pulse.
- Effective count: ecount = min(i_count, OPTN_ROM_DEPTH), latched at start. Internal remaining counter is CNT_WIDTH bits.
- ROM address: o_rom_rd_addr = OPTN_BASE_ADDR + idx (combinational from the idx register).
- FSM states: IDLE, SEND, DONE.
  - IDLE, i_start=1, ecount>0:
    - Set idx=0.
    - Capture i_rom_data_in at OPTN_BASE_ADDR into o_wr_data; set o_wr_addr=OPTN_DEST_BASE.
    - Set remaining=ecount; go to SEND.
    - o_wr_valid is high in the next cycle (latency 1 from start).
  - IDLE, i_start=1, ecount=0: go to DONE with no writes.
  - SEND:
    - o_wr_valid=1.
    - o_wr_data and o_wr_addr stay stable while !i_wr_ready.
    - On handshake with remaining>1: idx++; o_wr_data <= rom word at the next address (o_rom_rd_addr is presented combinationally from idx+1 in that cycle); o_wr_addr++; remaining--; stay in SEND. This gives one word per cycle under continuous ready.
    - On handshake with remaining==1: o_wr_valid=0 next cycle; go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE; idx returns to 0.
- i_start outside IDLE is ignored; it is not queued.
- Address wrap: idx never exceeds OPTN_ROM_DEPTH-1 because of the clamp. o_wr_addr wraps modulo 2^OPTN_DEST_ADDR_WIDTH.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: PROCYON_ROM_LOADER_CHECKSUM_EN.
- When defined:
  - Extra output port o_checksum (OPTN_DATA_WIDTH).
  - Cleared to 0 on reset and on each accepted start.
  - XORs in o_wr_data on every valid && ready handshake.
  - Final value is stable when o_done is high and is held until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- ROM preloaded with 0x10..0x17 (depth 8, base 0, dest base 0x100). Start, count=8, ready held 1 at cycle t -> valid high cycles t+1..t+8, data 0x10..0x17, addr 0x100..0x107, o_done pulse at t+9, o_busy high t+1..t+9.
- Same transfer with ready low on every other cycle -> data/addr held stable while valid && !ready; exactly 8 handshakes in order; done one cycle after the last handshake.
- count=0 -> no valid ever; o_done at t+1 only.
- count=12 -> clamped; exactly 8 writes 0x10..0x17, then done.
- Assert n_rst low for one cycle after 3 handshakes -> next cycle valid=0, busy=0, no done pulse; a new start with count=2 writes 0x10, 0x11 at addresses 0x100, 0x101.
- With PROCYON_ROM_LOADER_CHECKSUM_EN, count=3 -> o_checksum=0x13 at done; i_start asserted while busy is ignored with no effect on the data stream.
